uart_tx_feeder: RTL and testbench

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_word_fifo.sv | 70 +++++++
 rtl/uart_tx_feeder.sv | 104 ++++++++++
 tb/tb_uart_tx_feeder.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit feeder.
package uart_pkg;

  localparam int unsigned WORD_W             = 32;
  localparam int unsigned DEFAULT_DEPTH      = 8;
  localparam int unsigned DEFAULT_GAP_CYCLES = 2;
  localparam int unsigned GAP_CNT_W          = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_word_fifo.sv
// Word FIFO with registered occupancy and a registered not-full (ready) flag.
module uart_word_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  output logic                   wr_ready,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             wr_ready_q, wr_ready_d;
  logic             do_push_c, do_pop_c;

  // Ready is registered from the next level so it never depends on in_valid combinationally.
  always_comb begin
    do_push_c  = push && wr_ready_q;
    do_pop_c   = pop && (level_q != '0);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    if (do_push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push_c, do_pop_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    wr_ready_d = (level_d != LVL_W'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      wr_ready_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  // Storage is not reset; contents are only read while non-empty.
  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign level    = level_q;
  assign wr_ready = wr_ready_q;
  assign empty_c  = (level_q == '0);

endmodule

// File: rtl/uart_tx_feeder.sv
// Feeds buffered 32-bit words to a UART transmitter one frame at a time,
// with a fixed idle gap after each frame-complete indication.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH      = DEFAULT_DEPTH,
  parameter int unsigned GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
  input  logic                   iclk,
  input  logic                   irst_n,
  input  logic                   in_valid,
  input  logic [WORD_W-1:0]      in_data,
  output logic                   in_ready,
  output logic                   tx_data_valid,
  output logic [WORD_W-1:0]      tx_byte,
  input  logic                   tx_done,
  input  logic                   tx_active,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy
);

  tx_state_e              state_q, state_d;
  logic [GAP_CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic                   tx_done_q;
  logic                   tx_vld_q, tx_vld_d;
  logic [WORD_W-1:0]      tx_byte_q, tx_byte_d;
  logic                   busy_q, busy_d;
  logic                   pop_c;
  logic                   done_rise_c;
  logic                   fifo_empty_c;
  logic [WORD_W-1:0]      fifo_head_c;
  logic                   tx_active_unused_c;

  uart_word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk       (iclk),
    .rst_n     (irst_n),
    .push      (in_valid),
    .push_data (in_data),
    .wr_ready  (in_ready),
    .pop       (pop_c),
    .pop_data  (fifo_head_c),
    .level     (level),
    .empty_c   (fifo_empty_c)
  );

  // A held-high tx_done counts once: only a low-to-high change is a completion.
  assign done_rise_c        = tx_done && !tx_done_q;
  assign tx_active_unused_c = tx_active;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (!fifo_empty_c) state_d = ST_LAUNCH;
      ST_LAUNCH:    state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (done_rise_c) state_d = ST_GAP;
      ST_GAP:       if (gap_cnt_q == GAP_CNT_W'(GAP_CYCLES - 1)) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Pop and launch-register load happen together on the IDLE->LAUNCH transition.
  always_comb begin
    pop_c     = 1'b0;
    tx_vld_d  = 1'b0;
    tx_byte_d = tx_byte_q;
    gap_cnt_d = '0;
    busy_d    = (state_d != ST_IDLE);
    if (state_q == ST_IDLE && state_d == ST_LAUNCH) begin
      pop_c     = 1'b1;
      tx_vld_d  = 1'b1;
      tx_byte_d = fifo_head_c;
    end
    if (state_q == ST_GAP && state_d == ST_GAP) gap_cnt_d = gap_cnt_q + GAP_CNT_W'(1);
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      gap_cnt_q <= '0;
      tx_done_q <= 1'b0;
      tx_vld_q  <= 1'b0;
      tx_byte_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      gap_cnt_q <= gap_cnt_d;
      tx_done_q <= tx_done;
      tx_vld_q  <= tx_vld_d;
      tx_byte_q <= tx_byte_d;
      busy_q    <= busy_d;
    end
  end

  assign tx_data_valid = tx_vld_q;
  assign tx_byte       = tx_byte_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based timing model.
module tb_uart_tx_feeder;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned GAP   = 2;

  logic        iclk = 1'b0;
  logic        irst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        tx_data_valid;
  logic [31:0] tx_byte;
  logic        tx_done;
  logic        tx_active = 1'b0;
  logic [3:0]  level;
  logic        busy;

  logic man_done = 1'b0;
  logic auto_done = 1'b0;
  logic auto_en = 1'b0;
  assign tx_done = man_done | auto_done;

  int checks = 0;
  int failures = 0;

  uart_tx_feeder #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .iclk          (iclk),
    .irst_n        (irst_n),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .tx_data_valid (tx_data_valid),
    .tx_byte       (tx_byte),
    .tx_done       (tx_done),
    .tx_active     (tx_active),
    .level         (level),
    .busy          (busy)
  );

  always #5 iclk = ~iclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: words wait in a queue; a launch may happen on any edge at or after
  // free_edge when no frame is outstanding; a completion is a tx_done rise seen
  // at least two edges after the launch edge and opens the next slot GAP+1 edges later.
  logic [31:0] m_q [$];
  bit          m_ready = 1'b0;
  bit          m_vld = 1'b0;
  bit          m_busy = 1'b0;
  bit          outstanding = 1'b0;
  bit          prev_done = 1'b0;
  logic [31:0] m_byte = '0;
  int          k = 0;
  int          free_edge = 0;
  int          launch_edge = -10;
  int          m_sent = 0;
  int          dut_sent = 0;
  bit          cmp_en = 1'b0;
  bit          can_launch, rise, pushed;

  always @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      m_q.delete();
      m_ready = 1'b0; m_vld = 1'b0; m_busy = 1'b0; m_byte = '0;
      outstanding = 1'b0; prev_done = 1'b0; free_edge = 0; launch_edge = -10;
    end else begin
      k++;
      pushed     = in_valid && m_ready;
      can_launch = !outstanding && (k >= free_edge) && (m_q.size() > 0);
      rise       = tx_done && !prev_done;
      if (outstanding && rise && (k >= launch_edge + 2)) begin
        outstanding = 1'b0;
        free_edge   = k + GAP + 1;
      end
      prev_done = tx_done;
      m_vld = 1'b0;
      if (can_launch) begin
        m_byte      = m_q.pop_front();
        m_vld       = 1'b1;
        outstanding = 1'b1;
        launch_edge = k;
        m_sent++;
      end
      if (pushed) m_q.push_back(in_data);
      m_ready = (m_q.size() != DEPTH);
      m_busy  = outstanding || (k + 1 < free_edge);
    end
  end

  always @(negedge iclk) begin
    if (cmp_en) begin
      chk("cyc_in_ready", 32'(in_ready), 32'(m_ready));
      chk("cyc_tx_valid", 32'(tx_data_valid), 32'(m_vld));
      chk("cyc_tx_byte", tx_byte, m_byte);
      chk("cyc_level", 32'(level), 32'(m_q.size()));
      chk("cyc_busy", 32'(busy), 32'(m_busy));
      if (tx_data_valid) dut_sent++;
    end
  end

  // Random-latency UART responder, active only when auto_en is set.
  initial begin
    forever begin
      @(negedge iclk);
      if (auto_en && tx_data_valid) begin
        tx_active = 1'b1;
        repeat ($urandom_range(1, 8)) @(posedge iclk);
        #1 auto_done = 1'b1;
        repeat ($urandom_range(1, 3)) @(posedge iclk);
        #1 auto_done = 1'b0;
        tx_active = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int n = 0; n < 300 && !acc; n++) begin
      @(negedge iclk);
      acc = in_ready;
      step();
    end
    in_valid = 1'b0;
    if (!acc) chk("push_timeout", 32'(acc), 32'd1);
  endtask

  task automatic wait_launch(input string nm);
    bit got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge iclk);
      got = tx_data_valid;
    end
    chk(nm, 32'(got), 32'd1);
    step();
  endtask

  task automatic complete_and_wait(input string nm);
    man_done = 1'b1;
    step();
    man_done = 1'b0;
    wait_launch(nm);
  endtask

  task automatic complete_only();
    man_done = 1'b1;
    step();
    man_done = 1'b0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values and ready rising on the first edge after release.
    repeat (2) @(posedge iclk);
    cmp_en = 1'b1;
    @(negedge iclk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_tx_valid", 32'(tx_data_valid), 32'd0);
    chk("rst_tx_byte", tx_byte, 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    step();
    irst_n = 1'b1;
    @(negedge iclk);
    chk("rel_ready_before_edge", 32'(in_ready), 32'd0);
    step();
    @(negedge iclk);
    chk("rel_ready_after_edge", 32'(in_ready), 32'd1);
    step();

    // Single word: launch two cycles after the push cycle.
    push_word(32'hA5A5_0001);
    @(negedge iclk);
    chk("lat_n1_valid", 32'(tx_data_valid), 32'd0);
    step();
    @(negedge iclk);
    chk("lat_n2_valid", 32'(tx_data_valid), 32'd1);
    chk("lat_n2_byte", tx_byte, 32'hA5A5_0001);
    chk("lat_n2_busy", 32'(busy), 32'd1);
    step();
    step();
    man_done = 1'b1;
    for (int c = 1; c <= int'(GAP) + 1; c++) begin
      step();
      man_done = 1'b0;
      @(negedge iclk);
      chk("gap_busy", 32'(busy), (c <= int'(GAP)) ? 32'd1 : 32'd0);
    end
    chk("hold_byte", tx_byte, 32'hA5A5_0001);
    step();

    // Spurious completion while idle and empty.
    man_done = 1'b1;
    step();
    man_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge iclk);
      chk("spur_busy", 32'(busy), 32'd0);
      chk("spur_valid", 32'(tx_data_valid), 32'd0);
      step();
    end

    // Fill with a stalled UART, hold an extra word until a pop frees space.
    for (int i = 1; i <= 9; i++) push_word(32'h0000_0100 + 32'(i));
    @(negedge iclk);
    chk("fill_level", 32'(level), 32'd8);
    chk("fill_ready", 32'(in_ready), 32'd0);
    step();
    in_valid = 1'b1;
    in_data  = 32'h0000_010A;
    for (int c = 0; c < 4; c++) begin
      @(negedge iclk);
      chk("full_stall", 32'(in_ready), 32'd0);
      step();
    end
    man_done = 1'b1;
    step();
    man_done = 1'b0;
    push_word(32'h0000_010A);
    for (int i = 0; i < 8; i++) complete_and_wait("fill_drain");
    complete_only();
    repeat (6) step();

    // Double-length done, gap timing, and push+pop at level 3.
    for (int i = 0; i < 4; i++) push_word(32'h0000_0200 + 32'(i));
    repeat (8) step();
    @(negedge iclk);
    chk("pp_level_pre", 32'(level), 32'd3);
    step();
    man_done = 1'b1;
    @(negedge iclk);
    chk("gap_valid_0", 32'(tx_data_valid), 32'd0);
    for (int c = 1; c <= int'(GAP) + 2; c++) begin
      step();
      if (c == 2) man_done = 1'b0;
      in_valid = (c == int'(GAP) + 1);
      in_data  = 32'h0000_0204;
      @(negedge iclk);
      chk("gap_launch", 32'(tx_data_valid), (c == int'(GAP) + 2) ? 32'd1 : 32'd0);
      chk("pp_level", 32'(level), 32'd3);
    end
    chk("gap_byte", tx_byte, 32'h0000_0201);
    in_valid = 1'b0;
    step();
    for (int i = 0; i < 3; i++) complete_and_wait("pp_drain");
    complete_only();
    repeat (6) step();

    // Reset mid-frame with words queued.
    for (int i = 0; i < 5; i++) push_word(32'h0000_0300 + 32'(i));
    repeat (3) step();
    @(negedge iclk);
    chk("pre_rst_level", 32'(level), 32'd4);
    step();
    irst_n = 1'b0;
    #2;
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_byte", tx_byte, 32'd0);
    repeat (2) step();
    irst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge iclk);
      chk("post_rst_quiet", 32'(tx_data_valid), 32'd0);
      step();
    end
    push_word(32'h0000_03A0);
    wait_launch("post_rst_launch");
    chk("post_rst_byte", tx_byte, 32'h0000_03A0);
    complete_only();
    repeat (6) step();

    // Randomized traffic with a random-latency responder.
    auto_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) step();
      push_word($urandom());
    end
    for (int n = 0; n < 3000 && (m_q.size() != 0 || outstanding || m_busy); n++) step();
    repeat (12) step();
    auto_en = 1'b0;
    @(negedge iclk);
    chk("drain_level", 32'(level), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);
    chk("sent_count", 32'(dut_sent), 32'(m_sent));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
